// File: rtl/frv_bitwise_pkg.sv
// Shared constants for the frv_bitwise arbiter: uop bit positions, widths and requester ids.
package frv_bitwise_pkg;

  localparam int UOP_FSL      = 0;
  localparam int UOP_FSR      = 1;
  localparam int UOP_MROR     = 2;
  localparam int UOP_CMOV     = 3;
  localparam int UOP_LUT      = 4;
  localparam int UOP_BOP      = 5;
  localparam int UOP_W        = 6;
  localparam int RESULT_W_DEF = 64;
  localparam int NUM_REQ      = 2;

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;

endpackage

// File: rtl/frv_bitwise_arb_slot.sv
// Per-requester response register: captures on accept, drains on handshake, cleared by flush.
module frv_bitwise_arb_slot
  import frv_bitwise_pkg::*;
#(
  parameter int RESULT_W = RESULT_W_DEF
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                flush_i,
  input  logic                accept_i,
  input  logic                rsp_ready_i,
  input  logic [RESULT_W-1:0] result_i,
  output logic                rsp_valid_o,
  output logic [RESULT_W-1:0] rsp_result_o
);

  logic                valid_q, valid_d;
  logic [RESULT_W-1:0] result_q;

  // Flush wins; accept beats drain so a same-cycle drain+accept keeps valid high.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)                      valid_d = 1'b0;
    else if (accept_i)                valid_d = 1'b1;
    else if (valid_q && rsp_ready_i)  valid_d = 1'b0;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept_i) result_q <= result_i;
    end
  end

  assign rsp_valid_o  = valid_q;
  assign rsp_result_o = result_q;

endmodule

// File: rtl/frv_bitwise_arb.sv
// Two-requester arbiter and response buffer in front of one shared frv_bitwise unit.
// FRV_BITWISE_ARB_RR_EN selects round-robin; otherwise r0 has fixed priority.
module frv_bitwise_arb
  import frv_bitwise_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RESULT_W = RESULT_W_DEF
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                flush,
  input  logic                r0_req_valid,
  output logic                r0_req_ready,
  input  logic [UOP_W-1:0]    r0_uop,
  input  logic [XLEN-1:0]     r0_rs1,
  input  logic [XLEN-1:0]     r0_rs2,
  input  logic [XLEN-1:0]     r0_rs3,
  input  logic [7:0]          r0_bop_lut,
  output logic                r0_rsp_valid,
  input  logic                r0_rsp_ready,
  output logic [RESULT_W-1:0] r0_rsp_result,
  input  logic                r1_req_valid,
  output logic                r1_req_ready,
  input  logic [UOP_W-1:0]    r1_uop,
  input  logic [XLEN-1:0]     r1_rs1,
  input  logic [XLEN-1:0]     r1_rs2,
  input  logic [XLEN-1:0]     r1_rs3,
  input  logic [7:0]          r1_bop_lut,
  output logic                r1_rsp_valid,
  input  logic                r1_rsp_ready,
  output logic [RESULT_W-1:0] r1_rsp_result,
  output logic                bw_valid,
  output logic                bw_flush,
  output logic [XLEN-1:0]     bw_rs1,
  output logic [XLEN-1:0]     bw_rs2,
  output logic [XLEN-1:0]     bw_rs3,
  output logic [7:0]          bw_bop_lut,
  output logic                bw_uop_fsl,
  output logic                bw_uop_fsr,
  output logic                bw_uop_mror,
  output logic                bw_uop_cmov,
  output logic                bw_uop_lut,
  output logic                bw_uop_bop,
  input  logic [RESULT_W-1:0] bw_result,
  input  logic                bw_ready
);

  logic [NUM_REQ-1:0]                req_valid, rsp_valid, rsp_ready;
  logic [NUM_REQ-1:0]                elig, grant, accept;
  logic [NUM_REQ-1:0][UOP_W-1:0]     uop;
  logic [NUM_REQ-1:0][XLEN-1:0]      rs1, rs2, rs3;
  logic [NUM_REQ-1:0][7:0]           lut;
  logic [NUM_REQ-1:0][RESULT_W-1:0]  rsp_result;
  logic [UOP_W-1:0]                  bw_uop;

  assign req_valid = {r1_req_valid, r0_req_valid};
  assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};
  assign uop       = {r1_uop, r0_uop};
  assign rs1       = {r1_rs1, r0_rs1};
  assign rs2       = {r1_rs2, r0_rs2};
  assign rs3       = {r1_rs3, r0_rs3};
  assign lut       = {r1_bop_lut, r0_bop_lut};

  // Gating with g_resetn keeps every bw_* output low while reset is held.
  assign elig = req_valid & (~rsp_valid | rsp_ready) & {NUM_REQ{~flush & g_resetn}};

`ifdef FRV_BITWISE_ARB_RR_EN
  req_id_e last_grant_q, last_grant_d;
  logic    pref1;

  assign pref1    = (last_grant_q == REQ0);
  assign grant[0] = elig[0] & ~(elig[1] & pref1);
  assign grant[1] = elig[1] & ~grant[0];

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept[0])      last_grant_d = REQ0;
    else if (accept[1]) last_grant_d = REQ1;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) last_grant_q <= REQ1;
    else           last_grant_q <= last_grant_d;
  end
`else
  assign grant[0] = elig[0];
  assign grant[1] = elig[1] & ~elig[0];
`endif

  assign accept = grant & {NUM_REQ{bw_ready}};

  always_comb begin
    bw_valid   = |grant;
    bw_rs1     = '0;
    bw_rs2     = '0;
    bw_rs3     = '0;
    bw_bop_lut = '0;
    bw_uop     = '0;
    if (|grant) begin
      bw_rs1     = rs1[grant[1]];
      bw_rs2     = rs2[grant[1]];
      bw_rs3     = rs3[grant[1]];
      bw_bop_lut = lut[grant[1]];
      bw_uop     = uop[grant[1]];
    end
  end

  assign bw_flush    = flush & g_resetn;
  assign bw_uop_fsl  = bw_uop[UOP_FSL];
  assign bw_uop_fsr  = bw_uop[UOP_FSR];
  assign bw_uop_mror = bw_uop[UOP_MROR];
  assign bw_uop_cmov = bw_uop[UOP_CMOV];
  assign bw_uop_lut  = bw_uop[UOP_LUT];
  assign bw_uop_bop  = bw_uop[UOP_BOP];

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_slot
    frv_bitwise_arb_slot #(.RESULT_W(RESULT_W)) u_slot (
      .g_clk        (g_clk),
      .g_resetn     (g_resetn),
      .flush_i      (flush),
      .accept_i     (accept[n]),
      .rsp_ready_i  (rsp_ready[n]),
      .result_i     (bw_result),
      .rsp_valid_o  (rsp_valid[n]),
      .rsp_result_o (rsp_result[n])
    );
  end

  assign r0_req_ready  = accept[0];
  assign r1_req_ready  = accept[1];
  assign r0_rsp_valid  = rsp_valid[0];
  assign r1_rsp_valid  = rsp_valid[1];
  assign r0_rsp_result = rsp_result[0];
  assign r1_rsp_result = rsp_result[1];

endmodule

// File: tb/tb_frv_bitwise_arb.sv
// Directed bench for frv_bitwise_arb: per-cycle vector table plus a reset corner sequence.
module tb_frv_bitwise_arb;

`ifdef FRV_BITWISE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [5:0] U_FSL = 6'b000001, U_MROR = 6'b000100, U_CMOV = 6'b001000;

  logic        g_clk = 1'b0, g_resetn = 1'b0, flush = 1'b0;
  logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
  logic [5:0]  r0_uop;
  logic [31:0] r0_rs1, r0_rs2, r0_rs3;
  logic [7:0]  r0_bop_lut;
  logic [63:0] r0_rsp_result;
  logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
  logic [5:0]  r1_uop;
  logic [31:0] r1_rs1, r1_rs2, r1_rs3;
  logic [7:0]  r1_bop_lut;
  logic [63:0] r1_rsp_result;
  logic        bw_valid, bw_flush, bw_ready;
  logic [31:0] bw_rs1, bw_rs2, bw_rs3;
  logic [7:0]  bw_bop_lut;
  logic        bw_uop_fsl, bw_uop_fsr, bw_uop_mror, bw_uop_cmov, bw_uop_lut, bw_uop_bop;
  logic [63:0] bw_result;

  always #5 g_clk = ~g_clk;

  frv_bitwise_arb dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_uop(r0_uop),
    .r0_rs1(r0_rs1), .r0_rs2(r0_rs2), .r0_rs3(r0_rs3), .r0_bop_lut(r0_bop_lut),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_result(r0_rsp_result),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_uop(r1_uop),
    .r1_rs1(r1_rs1), .r1_rs2(r1_rs2), .r1_rs3(r1_rs3), .r1_bop_lut(r1_bop_lut),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_result(r1_rsp_result),
    .bw_valid(bw_valid), .bw_flush(bw_flush),
    .bw_rs1(bw_rs1), .bw_rs2(bw_rs2), .bw_rs3(bw_rs3), .bw_bop_lut(bw_bop_lut),
    .bw_uop_fsl(bw_uop_fsl), .bw_uop_fsr(bw_uop_fsr), .bw_uop_mror(bw_uop_mror),
    .bw_uop_cmov(bw_uop_cmov), .bw_uop_lut(bw_uop_lut), .bw_uop_bop(bw_uop_bop),
    .bw_result(bw_result), .bw_ready(bw_ready)
  );

  // Minimal model of the shared unit: ORs the results of the selected ops.
  always_comb begin
    logic [63:0] cat;
    logic [6:0]  sh;
    cat = {bw_rs1, bw_rs2};
    sh  = {1'b0, bw_rs3[5:0]};
    bw_result = '0;
    if (bw_uop_cmov) bw_result = bw_result | {32'h0, (bw_rs2 != 0) ? bw_rs1 : bw_rs3};
    if (bw_uop_mror) bw_result = bw_result | (cat >> sh) | (cat << (7'd64 - sh));
    if (bw_uop_fsl)  bw_result = bw_result | {32'h0, bw_rs1 << bw_rs3[4:0]};
  end

  typedef struct {
    bit v0; logic [5:0] u0; logic [31:0] a0, b0, c0; bit rr0;
    bit v1; logic [5:0] u1; logic [31:0] a1, b1, c1; bit rr1;
    bit fl, bwr;
    bit q0, q1, s0, s1;
    logic [63:0] e0, e1;
  } vec_t;

  int checks = 0, failures = 0;
  vec_t vecs[$];

  function automatic vec_t mk(bit v0, logic [5:0] u0, logic [31:0] a0, b0, c0, bit rr0,
                              bit v1, logic [5:0] u1, logic [31:0] a1, b1, c1, bit rr1,
                              bit fl, bit bwr, bit q0, bit q1, bit s0, bit s1,
                              logic [63:0] e0, logic [63:0] e1);
    vec_t v;
    v.v0 = v0; v.u0 = u0; v.a0 = a0; v.b0 = b0; v.c0 = c0; v.rr0 = rr0;
    v.v1 = v1; v.u1 = u1; v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rr1 = rr1;
    v.fl = fl; v.bwr = bwr; v.q0 = q0; v.q1 = q1; v.s0 = s0; v.s1 = s1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    r0_req_valid = v.v0; r0_uop = v.u0; r0_rs1 = v.a0; r0_rs2 = v.b0; r0_rs3 = v.c0;
    r0_rsp_ready = v.rr0;
    r1_req_valid = v.v1; r1_uop = v.u1; r1_rs1 = v.a1; r1_rs2 = v.b1; r1_rs3 = v.c1;
    r1_rsp_ready = v.rr1;
    flush = v.fl; bw_ready = v.bwr;
  endtask

  initial begin
    logic [63:0] M;
    vec_t idle;
    M = 64'h0000_0000_8000_0000;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    r0_bop_lut = 8'h00; r1_bop_lut = 8'hA5;
    drive(idle);

    // single r0 cmov, hold, drain
    vecs.push_back(mk(1, U_CMOV, 32'hDEADBEEF, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 0, 1, 0, 64'hDEADBEEF, 0));
    vecs.push_back(mk(0, U_CMOV, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      0, 0, 1, 0, 64'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1,
                      0, 0, 0, 0, 64'hDEADBEEF, 0));
    // r1 alone: fsl 3<<4, leaves pointer at r1
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, U_FSL, 3, 0, 4, 0, 0, 1,
                      0, 1, 0, 1, 64'hDEADBEEF, 64'h30));
    // contention, mror 1:0 by 1
    vecs.push_back(mk(1, U_MROR, 1, 0, 1, 1, 1, U_MROR, 1, 0, 1, 1, 0, 1,
                      1, 0, 1, 0, M, 64'h30));
    vecs.push_back(mk(1, U_MROR, 1, 0, 1, 1, 1, U_MROR, 1, 0, 1, 1, 0, 1,
                      !RR, RR, !RR, RR, M, RR ? M : 64'h30));
    vecs.push_back(mk(1, U_MROR, 1, 0, 1, 1, 1, U_MROR, 1, 0, 1, 1, 0, 1,
                      1, 0, 1, 0, M, RR ? M : 64'h30));
    vecs.push_back(mk(1, U_MROR, 1, 0, 1, 1, 1, U_MROR, 1, 0, 1, 1, 0, 1,
                      !RR, RR, !RR, RR, M, RR ? M : 64'h30));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1,
                      0, 0, 0, 0, M, RR ? M : 64'h30));
    // backpressure on r0, r1 proceeds, then r0 drain+accept same cycle
    vecs.push_back(mk(1, U_CMOV, 32'h11111111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 0, 1, 0, 64'h11111111, RR ? M : 64'h30));
    vecs.push_back(mk(1, U_CMOV, 32'h22222222, 1, 0, 0, 1, U_FSL, 1, 0, 8, 1, 0, 1,
                      0, 1, 1, 1, 64'h11111111, 64'h100));
    vecs.push_back(mk(1, U_CMOV, 32'h22222222, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 0, 1, 1, 64'h22222222, 64'h100));
    // flush with both pending, both requesting, both ready
    vecs.push_back(mk(1, U_CMOV, 32'h33333333, 1, 0, 1, 1, U_CMOV, 32'h44444444, 1, 0, 1, 1, 1,
                      0, 0, 0, 0, 64'h22222222, 64'h100));
    // pointer unchanged by flush: last was r0, so RR prefers r1
    vecs.push_back(mk(1, U_CMOV, 32'hA, 1, 0, 1, 1, U_CMOV, 32'hB, 1, 0, 1, 0, 1,
                      !RR, RR, !RR, RR, RR ? 64'h22222222 : 64'hA, RR ? 64'hB : 64'h100));
    // unit stalls two cycles on r1, then accepts
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, U_CMOV, 32'hC, 1, 0, 1, 0, 0,
                      0, 0, 0, 0, RR ? 64'h22222222 : 64'hA, RR ? 64'hB : 64'h100));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, U_CMOV, 32'hC, 1, 0, 1, 0, 0,
                      0, 0, 0, 0, RR ? 64'h22222222 : 64'hA, RR ? 64'hB : 64'h100));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, U_CMOV, 32'hC, 1, 0, 0, 0, 1,
                      0, 1, 0, 1, RR ? 64'h22222222 : 64'hA, 64'hC));
    // leave r0 response pending for the reset corner
    vecs.push_back(mk(1, U_CMOV, 32'hD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                      1, 0, 1, 1, 64'hD, 64'hC));

    repeat (3) @(posedge g_clk);
    #1;
    chk("rst.bw_valid", bw_valid, 0);
    chk("rst.sv0", r0_rsp_valid, 0);
    chk("rst.res1", r1_rsp_result, 0);
    @(negedge g_clk);
    g_resetn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge g_clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.rq0", i), r0_req_ready, vecs[i].q0);
      chk($sformatf("v%0d.rq1", i), r1_req_ready, vecs[i].q1);
      if (vecs[i].fl) chk($sformatf("v%0d.bw_flush", i), bw_flush, 1);
      @(posedge g_clk);
      #1;
      chk($sformatf("v%0d.sv0", i), r0_rsp_valid, vecs[i].s0);
      chk($sformatf("v%0d.sv1", i), r1_rsp_valid, vecs[i].s1);
      chk($sformatf("v%0d.res0", i), r0_rsp_result, vecs[i].e0);
      chk($sformatf("v%0d.res1", i), r1_rsp_result, vecs[i].e1);
    end

    // asynchronous reset mid-response, with r0 still requesting
    @(negedge g_clk);
    #1;
    g_resetn = 1'b0;
    #1;
    chk("arst.sv0", r0_rsp_valid, 0);
    chk("arst.sv1", r1_rsp_valid, 0);
    chk("arst.res0", r0_rsp_result, 0);
    chk("arst.res1", r1_rsp_result, 0);
    chk("arst.bw_valid", bw_valid, 0);
    chk("arst.bw_cmov", bw_uop_cmov, 0);
    chk("arst.rq0", r0_req_ready, 0);

    // first contention after reset goes to r0
    @(negedge g_clk);
    g_resetn = 1'b1;
    drive(vecs[4]);
    #1;
    chk("post.rq0", r0_req_ready, 1);
    chk("post.rq1", r1_req_ready, 0);
    chk("post.bw_mror", bw_uop_mror, 1);
    chk("post.bw_cmov", bw_uop_cmov, 0);
    @(posedge g_clk);
    #1;
    chk("post.res0", r0_rsp_result, M);
    chk("post.sv1", r1_rsp_valid, 0);
    @(negedge g_clk);
    drive(idle);
    #1;
    chk("idle.bw_valid", bw_valid, 0);
    chk("idle.bw_mror", bw_uop_mror, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
